// File: rtl/cory_xbar.sv
// cory_xbar: I-input, O-output crossbar with per-output round-robin arbitration
// and a one-entry registered slice on every output.
// Optional packet mode (macro CORY_XBAR_PKT_EN): an output stays locked to the
// input that started a packet until the beat flagged last has been accepted.
// Inputs addressing a nonexistent output are accepted and their beats dropped.
module cory_xbar #(
  parameter int unsigned N = 8,
  parameter int unsigned I = 4,
  parameter int unsigned O = 4,
  localparam int unsigned SW = (O > 1) ? $clog2(O) : 1,
  localparam int unsigned IW = (I > 1) ? $clog2(I) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [I-1:0]    i_a_v,
  input  logic [I*N-1:0]  i_a_d,
  input  logic [I*SW-1:0] i_a_s,
  input  logic [I-1:0]    i_a_l,
  output logic [I-1:0]    o_a_r,
  output logic [O-1:0]    o_z_v,
  output logic [O*N-1:0]  o_z_d,
  output logic [O*IW-1:0] o_z_i,
  output logic [O-1:0]    o_z_l,
  input  logic [O-1:0]    i_z_r
);

  logic [O-1:0][IW-1:0] ptr_q;
  logic [O-1:0][IW-1:0] ptr_nxt;
  logic [O-1:0][I-1:0]  req;
  logic [O-1:0]         slot_free;
  logic [O-1:0]         gnt_any;
  logic [O-1:0][IW-1:0] gnt_idx;
`ifdef CORY_XBAR_PKT_EN
  logic [O-1:0]         lock_q;
  logic [O-1:0][IW-1:0] lock_src_q;
`endif

  // Request matrix: input k asks for output j when valid and addressed to j
  always_comb begin
    req = '0;
    for (int k = 0; k < I; k++) begin
      for (int j = 0; j < O; j++) begin
        if (i_a_v[k] && (i_a_s[k*SW +: SW] == SW'(j))) req[j][k] = 1'b1;
      end
    end
  end

  // Per-output round-robin search starting at the pointer; a full slot grants nobody
  always_comb begin
    int unsigned idx;
    logic        elig;
    idx       = 0;
    elig      = 1'b0;
    gnt_any   = '0;
    gnt_idx   = '0;
    slot_free = '0;
    ptr_nxt   = '0;
    for (int j = 0; j < O; j++) begin
      slot_free[j] = !o_z_v[j] || i_z_r[j];
      for (int unsigned off = 0; off < I; off++) begin
        idx = 32'(ptr_q[j]) + off;
        if (idx >= I) idx = idx - I;
`ifdef CORY_XBAR_PKT_EN
        elig = req[j][IW'(idx)] && (!lock_q[j] || (lock_src_q[j] == IW'(idx)));
`else
        elig = req[j][IW'(idx)];
`endif
        if (!gnt_any[j] && elig && slot_free[j]) begin
          gnt_any[j] = 1'b1;
          gnt_idx[j] = IW'(idx);
        end
      end
      ptr_nxt[j] = ((32'(gnt_idx[j]) + 1) >= I) ? '0 : IW'(32'(gnt_idx[j]) + 1);
    end
  end

  // Input ready: granted by its addressed output, or addressed out of range (drop)
  always_comb begin
    o_a_r = '0;
    if (!reset) begin
      for (int k = 0; k < I; k++) begin
        if (32'(i_a_s[k*SW +: SW]) >= O) begin
          o_a_r[k] = 1'b1;
        end else begin
          for (int j = 0; j < O; j++) begin
            if ((i_a_s[k*SW +: SW] == SW'(j)) && gnt_any[j] && (gnt_idx[j] == IW'(k)))
              o_a_r[k] = 1'b1;
          end
        end
      end
    end
  end

  // Output slices, pointers and packet locks
  always_ff @(posedge clk) begin
    if (reset) begin
      o_z_v <= '0;
      o_z_d <= '0;
      o_z_i <= '0;
      o_z_l <= '0;
      ptr_q <= '0;
`ifdef CORY_XBAR_PKT_EN
      lock_q     <= '0;
      lock_src_q <= '0;
`endif
    end else begin
      for (int j = 0; j < O; j++) begin
        if (gnt_any[j]) begin
          o_z_v[j]          <= 1'b1;
          o_z_d[j*N +: N]   <= i_a_d[32'(gnt_idx[j])*N +: N];
          o_z_i[j*IW +: IW] <= gnt_idx[j];
          o_z_l[j]          <= i_a_l[gnt_idx[j]];
`ifdef CORY_XBAR_PKT_EN
          if (i_a_l[gnt_idx[j]]) begin
            lock_q[j] <= 1'b0;
            ptr_q[j]  <= ptr_nxt[j];
          end else begin
            lock_q[j]     <= 1'b1;
            lock_src_q[j] <= gnt_idx[j];
          end
`else
          ptr_q[j] <= ptr_nxt[j];
`endif
        end else if (i_z_r[j]) begin
          o_z_v[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/cory_xbar.md
CORY_XBAR -- requirements
Module: cory_xbar

Interface
REQ-001 Parameter N, default 8: data width per port, 1..256.
REQ-002 Parameter I, default 4: input port count, 2..16; need not be a power of two.
REQ-003 Parameter O, default 4: output port count, 2..16; need not be a power of two.
REQ-004 Parameters SW = max(1, clog2(O)) and IW = max(1, clog2(I)) are derived and SHALL NOT be overridden.
REQ-005 Ports are listed one per line as name, direction, width, meaning.
REQ-006 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 i_a_v  in  I  per-input valid.
REQ-009 i_a_d  in  I*N  per-input data; input k occupies bits [k*N +: N].
REQ-010 i_a_s  in  I*SW  per-input destination output index.
REQ-011 i_a_l  in  I  per-input last-beat flag.
REQ-012 o_a_r  out  I  per-input ready.
REQ-013 o_z_v  out  O  per-output valid, registered.
REQ-014 o_z_d  out  O*N  per-output data, registered.
REQ-015 o_z_i  out  O*IW  source input index of the current output beat, registered.
REQ-016 o_z_l  out  O  last flag of the current output beat, registered.
REQ-017 i_z_r  in  O  per-output ready.
REQ-018 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-019 An input transfer SHALL occur on a cycle where i_a_v[k] and o_a_r[k] are both 1; an output transfer SHALL occur where o_z_v[j] and i_z_r[j] are both 1.
REQ-020 An input SHALL hold v/d/s/l stable while valid and not ready; the block does not check this.
REQ-021 Output j SHALL have a one-entry register slice; the slot is free when !o_z_v[j] || i_z_r[j].
REQ-022 Input-to-output latency SHALL be 1 cycle; with i_z_r held at 1, each output sustains 1 beat/cycle.
REQ-023 Output j's requesters SHALL be all inputs k with i_a_v[k]=1 and i_a_s[k]=j.
REQ-024 Output j SHALL round-robin arbitrate its requesters. Pointer p_j is the highest-priority index; search order is p_j, p_j+1, ... mod I.
REQ-025 o_a_r[k] SHALL be 1 only when k is granted by output i_a_s[k] and that output's slot is free. o_a_r may depend combinationally on i_z_r.
REQ-026 On an input transfer from k to output j, output j SHALL load d, k and l, set o_z_v[j]=1, and set p_j = (k+1) mod I.
REQ-027 On an output transfer with no new load, o_z_v[j] SHALL clear the next cycle. A simultaneous output transfer and load SHALL replace the beat with no bubble.
REQ-028 With no requesters, p_j SHALL be unchanged; a slot that is not free SHALL grant nobody and leave p_j unchanged.
REQ-029 An input with i_a_s[k] >= O SHALL see o_a_r[k]=1; the beat is discarded and appears on no output.
REQ-030 Distinct outputs SHALL arbitrate independently. Up to min(I,O) transfers may occur in one cycle.

Reset
REQ-031 While reset=1: o_z_v=0, o_z_d=0, o_z_i=0, o_z_l=0, all p_j=0, all locks clear, o_a_r=0.
REQ-032 Reset asserted mid-packet or mid-stall SHALL discard held beats and locks; the first cycle after deassertion behaves as post-reset idle.

Configuration
REQ-033 The macro CORY_XBAR_PKT_EN SHALL select packet mode.
REQ-034 With CORY_XBAR_PKT_EN defined, an input transfer with i_a_l=0 SHALL lock output j to input k. While locked, only k may be granted and p_j SHALL be frozen.
REQ-035 With CORY_XBAR_PKT_EN defined, the lock SHALL release after the transfer with i_a_l=1; p_j then updates per REQ-026.
REQ-036 Without CORY_XBAR_PKT_EN, arbitration SHALL be per beat and i_a_l SHALL only be forwarded to o_z_l.

Verification
REQ-037 I=O=4, N=8, inputs 0..3 valid with s=0, data 0xA0..0xA3, i_z_r=1 -> o_z_d[0] sequence 0xA0,0xA1,0xA2,0xA3 with o_z_i=0,1,2,3, one beat per cycle from cycle 1.
REQ-038 Input k sends 0x10+k to output 3-k, all ready -> every o_z_v=1 in the same cycle; o_z_d[j]=0x13-j.
REQ-039 Output 1 held with i_z_r[1]=0 for 5 cycles while input 2 sends 0x55 then 0x66 -> o_z_d[1]=0x55 stable, o_a_r[2]=0 after the first beat, no loss or duplication.
REQ-040 With PKT_EN: input 0 sends a 3-beat packet (l=0,0,1) and input 1 a 1-beat packet, both to output 2 -> output order 0,0,0,1. Without PKT_EN the order interleaves: 0,1,0,0.
REQ-041 I=3, O=3, i_a_s[1]=3 with v=1 -> o_a_r[1]=1 and no o_z_v asserts.
REQ-042 Assert reset for 1 cycle mid-packet while o_z_v[0]=1 -> next cycle all outputs are 0 and p_j=0; a fresh request from input 3 is granted immediately.
